// File: rtl/fc8_intc_if.sv
// CPU-side bus and interrupt-line bundle for the FC8 interrupt controller.
// master = CPU/bus side, slave = fc8_intc.
interface fc8_intc_if;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        we;
   logic [7:0]  rdata;
   logic [7:0]  src;
   logic        nmi_src;
   logic        irq_n;
   logic        nmi_n;

   modport master (output addr, wdata, we, src, nmi_src,
                   input  rdata, irq_n, nmi_n);
   modport slave  (input  addr, wdata, we, src, nmi_src,
                   output rdata, irq_n, nmi_n);
endinterface

// File: rtl/fc8_intc.sv
// FC8 interrupt controller: 8 edge-triggered maskable sources plus one NMI, 4-byte register window.
// Optional FC8_INTC_SYNC_EN inserts a 2-flop synchronizer in front of edge detect.
module fc8_intc #(
   parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
   input  logic       clk,
   input  logic       rst,
   fc8_intc_if.slave  bus
);
   logic [7:0] src_s;
   logic       nmi_s;

`ifdef FC8_INTC_SYNC_EN
   logic [7:0] src_m_q, src_s_q;
   logic       nmi_m_q, nmi_s_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_m_q <= 8'hFF;
         src_s_q <= 8'hFF;
         nmi_m_q <= 1'b1;
         nmi_s_q <= 1'b1;
      end else begin
         src_m_q <= bus.src;
         src_s_q <= src_m_q;
         nmi_m_q <= bus.nmi_src;
         nmi_s_q <= nmi_m_q;
      end
   end

   assign src_s = src_s_q;
   assign nmi_s = nmi_s_q;
`else
   assign src_s = bus.src;
   assign nmi_s = bus.nmi_src;
`endif

   logic [7:0] src_prev_q;
   logic       nmi_prev_q;
   logic [7:0] pend_q, pend_d;
   logic [7:0] en_q, en_d;
   logic       gie_q, gie_d;
   logic       ovf_q, ovf_d;
   logic       nmi_pend_q, nmi_pend_d;
   logic       irq_n_q, nmi_n_q;

   logic       hit, wr_status, wr_mask, wr_ctrl;
   logic [7:0] src_rise;
   logic       nmi_rise;
   logic [7:0] vector;
   logic [7:0] rdata_c;

   assign hit       = (bus.addr[15:2] == BASE_ADDR[15:2]);
   assign wr_status = bus.we & hit & (bus.addr[1:0] == 2'd0);
   assign wr_mask   = bus.we & hit & (bus.addr[1:0] == 2'd1);
   assign wr_ctrl   = bus.we & hit & (bus.addr[1:0] == 2'd3);

   assign src_rise = src_s & ~src_prev_q;
   assign nmi_rise = nmi_s & ~nmi_prev_q;

   // Sets are OR'd in after the clear so a coincident edge always wins.
   always_comb begin
      pend_d     = (pend_q & ~(wr_status ? bus.wdata : 8'h00)) | src_rise;
      ovf_d      = (ovf_q & ~(wr_ctrl & bus.wdata[6])) | (|(src_rise & pend_q));
      nmi_pend_d = (nmi_pend_q & ~(wr_ctrl & bus.wdata[1])) | nmi_rise;
      en_d       = wr_mask ? bus.wdata : en_q;
      gie_d      = wr_ctrl ? bus.wdata[0] : gie_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_prev_q <= 8'hFF;
         nmi_prev_q <= 1'b1;
         pend_q     <= 8'h00;
         en_q       <= 8'h00;
         gie_q      <= 1'b0;
         ovf_q      <= 1'b0;
         nmi_pend_q <= 1'b0;
         irq_n_q    <= 1'b1;
         nmi_n_q    <= 1'b1;
      end else begin
         src_prev_q <= src_s;
         nmi_prev_q <= nmi_s;
         pend_q     <= pend_d;
         en_q       <= en_d;
         gie_q      <= gie_d;
         ovf_q      <= ovf_d;
         nmi_pend_q <= nmi_pend_d;
         irq_n_q    <= ~(gie_q & (|(pend_q & en_q)));
         nmi_n_q    <= ~nmi_pend_q;
      end
   end

   always_comb begin
      vector = 8'hFF;
      for (int i = 7; i >= 0; i--) begin
         if (pend_q[i] & en_q[i]) vector = 8'(i);
      end
   end

   always_comb begin
      rdata_c = 8'h00;
      if (hit) begin
         case (bus.addr[1:0])
            2'd0: rdata_c = pend_q;
            2'd1: rdata_c = en_q;
            2'd2: rdata_c = vector;
            2'd3: rdata_c = {ovf_q, 4'b0000, nmi_pend_q, 1'b0, gie_q};
            default: rdata_c = 8'h00;
         endcase
      end
   end

   assign bus.rdata = rdata_c;
   assign bus.irq_n = irq_n_q;
   assign bus.nmi_n = nmi_n_q;
endmodule

// File: tb/tb_fc8_intc.sv
// Self-checking bench for fc8_intc: directed vector table, reset sequences and
// randomized traffic checked against a behavioural model.
module tb_fc8_intc;
   localparam logic [15:0] BASE = 16'hFF00;
`ifdef FC8_INTC_SYNC_EN
   localparam int SYNC_DLY = 2;
`else
   localparam int SYNC_DLY = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   fc8_intc_if bus();

   fc8_intc #(.BASE_ADDR(BASE)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model state
   logic [7:0] m_pend, m_en, m_prev;
   logic       m_gie, m_ovf, m_nmi, m_nprev, m_irq_n, m_nmi_n;
   logic [7:0] hist_s [3];
   logic       hist_n [3];

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic        we;
      logic [7:0]  src;
      logic        nmi;
      logic [15:0] chk_addr;
      logic [7:0]  exp_rd;
      logic        exp_irq_n;
      logic        exp_nmi_n;
   } row_t;
   row_t rows [$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = 8'h00; m_en = 8'h00; m_gie = 1'b0; m_ovf = 1'b0; m_nmi = 1'b0;
      m_irq_n = 1'b1; m_nmi_n = 1'b1; m_prev = 8'hFF; m_nprev = 1'b1;
      for (int k = 0; k < 3; k++) begin
         hist_s[k] = 8'hFF;
         hist_n[k] = 1'b1;
      end
   endtask

   task automatic model_step();
      logic [7:0] s, newp;
      logic       n, wr, ovfset;
      logic [1:0] off;
      wr  = bus.we && (bus.addr / 4 == BASE / 4);
      off = bus.addr[1:0];
      m_irq_n = !(m_gie && ((m_pend & m_en) != 0));
      m_nmi_n = !m_nmi;
      hist_s[2] = hist_s[1]; hist_s[1] = hist_s[0]; hist_s[0] = bus.src;
      hist_n[2] = hist_n[1]; hist_n[1] = hist_n[0]; hist_n[0] = bus.nmi_src;
      s = hist_s[SYNC_DLY];
      n = hist_n[SYNC_DLY];
      ovfset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (s[i] && !m_prev[i]) begin
            if (m_pend[i]) ovfset = 1'b1;
            newp[i] = 1'b1;
         end else if (wr && off == 0 && bus.wdata[i]) newp[i] = 1'b0;
         else newp[i] = m_pend[i];
      end
      m_prev = s;
      if (ovfset) m_ovf = 1'b1;
      else if (wr && off == 3 && bus.wdata[6]) m_ovf = 1'b0;
      if (n && !m_nprev) m_nmi = 1'b1;
      else if (wr && off == 3 && bus.wdata[1]) m_nmi = 1'b0;
      m_nprev = n;
      if (wr && off == 1) m_en = bus.wdata;
      if (wr && off == 3) m_gie = bus.wdata[0];
      m_pend = newp;
   endtask

   function automatic logic [7:0] model_reg(input int off);
      logic [7:0] v;
      case (off)
         0: v = m_pend;
         1: v = m_en;
         2: begin
            v = 8'hFF;
            for (int i = 7; i >= 0; i--) if (m_pend[i] && m_en[i]) v = 8'(i);
         end
         default: v = {m_ovf, 4'b0000, m_nmi, 1'b0, m_gie};
      endcase
      return v;
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic read(input logic [15:0] a, output logic [7:0] d);
      bus.we = 1'b0;
      bus.addr = a;
      #1;
      d = bus.rdata;
   endtask

   task automatic check_model();
      logic [7:0] d;
      for (int off = 0; off < 4; off++) begin
         read(BASE + 16'(off), d);
         chk($sformatf("model reg+%0d", off), d, model_reg(off));
      end
      chk("model irq_n", {7'b0, bus.irq_n}, {7'b0, m_irq_n});
      chk("model nmi_n", {7'b0, bus.nmi_n}, {7'b0, m_nmi_n});
   endtask

   task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w,
                        input logic [7:0] s, input logic n);
      bus.addr = a; bus.wdata = d; bus.we = w; bus.src = s; bus.nmi_src = n;
   endtask

   task automatic add(input logic [15:0] a, input logic [7:0] d, input logic w,
                      input logic [7:0] s, input logic n, input logic [15:0] ca,
                      input logic [7:0] e, input logic ei, input logic en);
      row_t r;
      r.addr = a; r.wdata = d; r.we = w; r.src = s; r.nmi = n;
      r.chk_addr = ca; r.exp_rd = e; r.exp_irq_n = ei; r.exp_nmi_n = en;
      rows.push_back(r);
   endtask

   initial begin
      logic [7:0] d;
      int waited;

      //        addr      wdata  we  src    nmi  chk_addr  exp    irq_n nmi_n
      add(16'hFF01, 8'h05, 1, 8'h00, 0, 16'hFF01, 8'h05, 1, 1);
      add(16'hFF03, 8'h01, 1, 8'h00, 0, 16'hFF03, 8'h01, 1, 1);
      add(16'hFF00, 8'h00, 0, 8'h04, 0, 16'hFF00, 8'h04, 1, 1);
      add(16'hFF00, 8'h00, 0, 8'h00, 0, 16'hFF02, 8'h02, 0, 1);
      add(16'hFF00, 8'h04, 1, 8'h00, 0, 16'hFF00, 8'h00, 0, 1);
      add(16'hFF00, 8'h00, 0, 8'h00, 0, 16'hFF00, 8'h00, 1, 1);
      add(16'hFF01, 8'h80, 1, 8'h00, 0, 16'hFF01, 8'h80, 1, 1);
      add(16'hFF00, 8'h00, 0, 8'h88, 0, 16'hFF00, 8'h88, 1, 1);
      add(16'hFF00, 8'h00, 0, 8'h00, 0, 16'hFF02, 8'h07, 0, 1);
      add(16'hFF01, 8'h88, 1, 8'h00, 0, 16'hFF02, 8'h03, 0, 1);
      add(16'hFF03, 8'h00, 1, 8'h00, 0, 16'hFF00, 8'h88, 0, 1);
      add(16'hFF00, 8'h00, 0, 8'h00, 0, 16'hFF00, 8'h88, 1, 1);
      add(16'hFF00, 8'hFF, 1, 8'h00, 0, 16'hFF00, 8'h00, 1, 1);
      add(16'hFF00, 8'h01, 1, 8'h01, 0, 16'hFF00, 8'h01, 1, 1);
      add(16'hFF00, 8'h00, 0, 8'h00, 0, 16'hFF03, 8'h00, 1, 1);
      add(16'hFF00, 8'h00, 0, 8'h01, 0, 16'hFF03, 8'h80, 1, 1);
      add(16'hFF03, 8'h40, 1, 8'h00, 0, 16'hFF03, 8'h00, 1, 1);
      add(16'hFF01, 8'h00, 1, 8'h00, 1, 16'hFF03, 8'h04, 1, 1);
      add(16'hFF00, 8'h00, 0, 8'h00, 0, 16'hFF03, 8'h04, 1, 0);
      add(16'hFF03, 8'h02, 1, 8'h00, 0, 16'hFF03, 8'h00, 1, 0);
      add(16'hFF00, 8'h00, 0, 8'h00, 0, 16'hFF03, 8'h00, 1, 1);
      add(16'hFF01, 8'h5A, 1, 8'h00, 0, 16'hFF01, 8'h5A, 1, 1);
      add(16'hFF05, 8'h00, 1, 8'h00, 0, 16'hFF01, 8'h5A, 1, 1);
      add(16'hFF04, 8'hFF, 1, 8'h00, 0, 16'h1234, 8'h00, 1, 1);

      // sources held high across reset release must not register edges
      drive(BASE, 8'h00, 1'b0, 8'hFF, 1'b1);
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #5 rst = 1'b0;
      tick();
      tick();
      read(BASE, d);
      chk("reset-hold STATUS", d, 8'h00);
      check_model();
      drive(BASE, 8'h00, 1'b0, 8'h00, 1'b0);
      tick();
      tick();
      check_model();

`ifndef FC8_INTC_SYNC_EN
      foreach (rows[r]) begin
         drive(rows[r].addr, rows[r].wdata, rows[r].we, rows[r].src, rows[r].nmi);
         tick();
         read(rows[r].chk_addr, d);
         chk($sformatf("row%0d rdata", r), d, rows[r].exp_rd);
         chk($sformatf("row%0d irq_n", r), {7'b0, bus.irq_n}, {7'b0, rows[r].exp_irq_n});
         chk($sformatf("row%0d nmi_n", r), {7'b0, bus.nmi_n}, {7'b0, rows[r].exp_nmi_n});
         check_model();
      end
`else
      // synchronized path: STATUS appears 2 edges later than the direct path
      drive(16'hFF01, 8'h05, 1'b1, 8'h00, 1'b0); tick();
      drive(16'hFF03, 8'h01, 1'b1, 8'h00, 1'b0); tick();
      drive(16'hFF00, 8'h00, 1'b0, 8'h04, 1'b0); tick();
      read(16'hFF00, d); chk("sync STATUS E", d, 8'h00);
      drive(16'hFF00, 8'h00, 1'b0, 8'h04, 1'b0); tick();
      read(16'hFF00, d); chk("sync STATUS E+1", d, 8'h00);
      drive(16'hFF00, 8'h00, 1'b0, 8'h04, 1'b0); tick();
      read(16'hFF00, d); chk("sync STATUS E+2", d, 8'h04);
      drive(16'hFF00, 8'h00, 1'b0, 8'h00, 1'b0); tick();
      chk("sync irq_n", {7'b0, bus.irq_n}, 8'h00);
      check_model();
`endif

      // async reset while irq_n is asserted
      drive(16'hFF01, 8'h01, 1'b1, 8'h00, 1'b0); tick();
      drive(16'hFF00, 8'hFF, 1'b1, 8'h00, 1'b0); tick();
      drive(16'hFF03, 8'h01, 1'b1, 8'h01, 1'b0); tick();
      drive(BASE, 8'h00, 1'b0, 8'h01, 1'b0);
      waited = 0;
      while (bus.irq_n !== 1'b0 && waited < 10) begin
         tick();
         waited++;
      end
      chk("pre-reset irq_n", {7'b0, bus.irq_n}, 8'h00);
      check_model();
      #1 rst = 1'b1;
      model_reset();
      #1;
      chk("async rst irq_n", {7'b0, bus.irq_n}, 8'h01);
      chk("async rst nmi_n", {7'b0, bus.nmi_n}, 8'h01);
      read(16'hFF00, d); chk("async rst STATUS", d, 8'h00);
      read(16'hFF01, d); chk("async rst MASK", d, 8'h00);
      read(16'hFF02, d); chk("async rst VECTOR", d, 8'hFF);
      read(16'hFF03, d); chk("async rst CTRL", d, 8'h00);
      #1 rst = 1'b0;
      tick();
      check_model();

      // randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         logic [15:0] a;
         int sel;
         sel = $urandom_range(0, 9);
         if (sel <= 6)      a = BASE + 16'($urandom_range(0, 3));
         else if (sel == 7) a = BASE + 16'd4 + 16'($urandom_range(0, 3));
         else if (sel == 8) a = BASE - 16'd4 + 16'($urandom_range(0, 3));
         else               a = 16'($urandom);
         drive(a, 8'($urandom), ($urandom_range(0, 2) == 0),
               bus.src ^ (8'($urandom) & 8'($urandom) & 8'($urandom)),
               ($urandom_range(0, 3) == 0) ? ~bus.nmi_src : bus.nmi_src);
         tick();
         check_model();
         if ($urandom_range(0, 99) == 0) begin
            rst = 1'b1;
            model_reset();
            #1 rst = 1'b0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fc8_intc.md
FC8_INTC -- requirements
Module: fc8_intc

Interface
REQ-001 Parameter BASE_ADDR, default 16'hFF00, sets the 4-byte register window at BASE_ADDR..BASE_ADDR+3, selected on addr[15:2] match.
REQ-002 The clock port is clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The reset port is rst, input, 1 bit: reset is asynchronous and active-high.
REQ-004 addr, input, 16 bits: the CPU logical address bus.
REQ-005 wdata, input, 8 bits: CPU write data, driven from the CPU data_out port.
REQ-006 we, input, 1 bit: CPU write enable.
REQ-007 rdata, output, 8 bits: read data, which the bus mux ORs into the CPU data_in port.
REQ-008 src, input, 8 bits: maskable interrupt sources, rising-edge triggered; bit 0 has the highest priority.
REQ-009 nmi_src, input, 1 bit: non-maskable source, rising-edge triggered.
REQ-010 irq_n, output, 1 bit: active-low maskable request to the CPU.
REQ-011 nmi_n, output, 1 bit: active-low non-maskable request to the CPU.

Function
REQ-012 The register map SHALL be:
- +0 STATUS: reads pend[7:0]; writing 1 to a bit clears that bit.
- +1 MASK: read/write enable[7:0].
- +2 VECTOR: read-only.
- +3 CTRL: bit0 GIE (read/write); bit1 written 1 clears nmi_pend; bit6 written 1 clears OVF; bit7 reads OVF; bit2 reads nmi_pend; all other bits read 0.
REQ-013 rdata SHALL be combinational from addr and register state: the selected register when the window is hit, 8'h00 otherwise; reads SHALL have no side effects.
REQ-014 A write SHALL take effect at the clk edge where we=1 and the window is hit; writes outside the window SHALL be ignored.
REQ-015 Edge detect SHALL register the previous source sample; pend[i] sets at the edge where the sample is 1 and the previous sample was 0.
REQ-016 If a set and a write-1-clear hit the same pend bit in the same cycle, set SHALL win.
REQ-017 An edge arriving on src[i] while pend[i]=1 SHALL set the sticky OVF bit; if set and clear coincide on OVF, set wins.
REQ-018 VECTOR SHALL read the lowest index i with pend[i]&enable[i]=1, or 8'hFF if there is none; MASK and GIE do not gate pend.
REQ-019 irq_n SHALL be registered and equal ~(GIE & |(pend & enable)), so it is asserted one cycle after the pend bit updates.
REQ-020 nmi_pend SHALL set on an nmi_src rising edge and hold until cleared via CTRL bit1; set wins over a simultaneous clear.
REQ-021 nmi_n SHALL be registered ~nmi_pend and SHALL be independent of GIE and MASK.
REQ-022 Latency without the synchronizer: if a source rises before edge E, the STATUS bit is 1 after E and irq_n/nmi_n are 0 after E+1.
REQ-023 Deasserting irq_n after a clear, mask or GIE write SHALL also take one cycle after the register update.

Reset
REQ-024 While rst=1, the block SHALL set pend=0, enable=0, GIE=0, nmi_pend=0 and OVF=0.
REQ-025 While rst=1, the block SHALL set irq_n=1 and nmi_n=1.
REQ-026 While rst=1, the edge-detect previous-sample registers SHALL be all-ones, so a source already high at release creates no edge.
REQ-027 Synchronizer flops, if present, SHALL reset to all-ones.
REQ-028 rdata SHALL follow REQ-013 during reset, since it is combinational.
REQ-029 Reset asserted mid-operation SHALL discard all pending state immediately, without waiting for a clock.

Configuration
REQ-030 Macro FC8_INTC_SYNC_EN: when defined, src and nmi_src SHALL pass through a 2-flop synchronizer before edge detect, adding exactly 2 cycles to every REQ-022 latency.
REQ-031 When FC8_INTC_SYNC_EN is undefined, sources SHALL feed edge detect directly.
REQ-032 The register map and all other behaviour SHALL be identical with and without FC8_INTC_SYNC_EN.

Verification
REQ-033 Masked IRQ: reset; write MASK=8'h05 and CTRL=8'h01; pulse src[2] -> STATUS=8'h04, VECTOR=8'h02, irq_n=0 one cycle after the STATUS update; write STATUS=8'h04 -> irq_n=1 one cycle later.
REQ-034 Priority and mask: src[7] and src[3] rise together with MASK=8'h80 -> VECTOR=8'h07; then write MASK=8'h88 -> VECTOR=8'h03; write GIE=0 -> irq_n=1 and STATUS=8'h88 is unchanged.
REQ-035 Collision: write STATUS=8'h01 in the same cycle src[0] rises -> pend[0]=1; a second src[0] edge while pend[0]=1 -> CTRL reads 8'h80 with GIE=0; write CTRL=8'h40 -> OVF=0.
REQ-036 NMI: nmi_src rises with MASK=0 and GIE=0 -> nmi_n=0 and CTRL bit2=1; write CTRL=8'h02 -> nmi_n=1 one cycle later.
REQ-037 Reset: hold src=8'hFF across reset release -> STATUS=8'h00; assert rst while irq_n=0 -> irq_n=1 and all registers read 8'h00 (VECTOR reads 8'hFF) before the next clk edge.
REQ-038 Window and sync: a write to BASE_ADDR+4 changes nothing; a read outside the window returns 8'h00; with FC8_INTC_SYNC_EN defined, the REQ-033 STATUS update arrives 2 cycles later.
